// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, frame width, default baud
// and the oversample divider rounding used by both rx and tx.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_BAUD      = 19200;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_state_t;

    // Round-to-nearest sclk cycles per oversample tick.
    function automatic int uart_div(input int clk_hz, input int baud,
                                    input int os);
        return (clk_hz + (baud * os) / 2) / (baud * os);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: counts 0..DIV-1, tick on DIV-1,
// held at zero while clear is high so ticks align to the start edge.
module uart_baud_tick #(
    parameter int DIV = 163
) (
    input  logic sclk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == LAST);
    assign tick   = w_last && !clear;

    always_ff @(posedge sclk) begin
        if (reset || clear) begin
            r_cnt <= '0;
        end else if (w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 serial byte receiver with 2-flop input synchronizer,
// oversampled mid-bit sampling, framing-error and break handling.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = UART_BAUD,
    parameter int OVERSAMPLE = 16
) (
    input  logic                      sclk,
    input  logic                      reset,
    input  logic                      RxD,
    output logic [UART_DATA_BITS-1:0] rx_data,
    output logic                      rx_valid,
    output logic                      frame_err,
    output logic                      busy
);

    localparam int DIV = uart_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int OSW = $clog2(OVERSAMPLE);
    localparam logic [OSW-1:0] OS_MID  = OSW'(OVERSAMPLE / 2 - 1);
    localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
    localparam logic [2:0]     BIT_LAST = 3'(UART_DATA_BITS - 1);

    uart_state_t               r_state;
    logic [1:0]                r_sync;
    logic [OSW-1:0]            r_os;
    logic [2:0]                r_bit;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic                      w_rx_s;
    logic                      w_tick;
    logic                      w_clear;

    assign w_rx_s  = r_sync[1];
    assign w_clear = (r_state == IDLE);

    uart_baud_tick #(
        .DIV(DIV)
    ) u_tick (
        .sclk (sclk),
        .reset(reset),
        .clear(w_clear),
        .tick (w_tick)
    );

    always_ff @(posedge sclk) begin
        if (reset) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], RxD};
        end
    end

    always_ff @(posedge sclk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_os      <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (!w_rx_s) begin
                        r_state <= START;
                        r_os    <= '0;
                        r_bit   <= '0;
                        busy    <= 1'b1;
                    end
                end
                START: begin
                    if (w_tick) begin
                        if (r_os == OS_MID) begin
                            r_os <= '0;
                            if (w_rx_s) begin
                                r_state <= IDLE;
                                busy    <= 1'b0;
                            end else begin
                                r_state <= DATA;
                            end
                        end else begin
                            r_os <= r_os + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        if (r_os == OS_LAST) begin
                            r_os    <= '0;
                            r_shift <= {w_rx_s, r_shift[UART_DATA_BITS-1:1]};
                            r_bit   <= r_bit + 1'b1;
                            if (r_bit == BIT_LAST) begin
                                r_state <= STOP;
                            end
                        end else begin
                            r_os <= r_os + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        if (r_os == OS_LAST) begin
                            r_os <= '0;
                            busy <= 1'b0;
                            if (w_rx_s) begin
                                rx_data  <= r_shift;
                                rx_valid <= 1'b1;
                                r_state  <= IDLE;
                            end else begin
                                frame_err <= 1'b1;
                                r_state   <= BREAK;
                            end
                        end else begin
                            r_os <= r_os + 1'b1;
                        end
                    end
                end
                BREAK: begin
                    // Hold off until the line recovers so a stuck-low line
                    // cannot retrigger a new frame.
                    if (w_rx_s) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Self-checking bench for uart_rx_byte: directed frames plus randomized
// bytes/baud skew, checked against a queue-based expected-byte model.
`timescale 1ns/1ps
module tb_uart_rx_byte;

    localparam real CLK_NS = 10.0;
    localparam real BIT_NS = 1600.0;
    localparam real TX_NS  = 1600.0 * 19200.0 / 19201.0;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       RxD = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    int   n_vec = 0;
    int   n_err = 0;
    int   n_valid = 0;
    int   n_ferr = 0;
    int   exp_valid = 0;
    int   exp_ferr = 0;
    bit   busy_seen = 0;
    bit   prev_v = 0;
    bit   prev_f = 0;
    logic [7:0] last_good = 8'h00;
    logic [7:0] exp_q[$];

    always #(CLK_NS / 2) clk = ~clk;

    uart_rx_byte #(
        .CLK_HZ    (3_072_000),
        .BAUD      (19200),
        .OVERSAMPLE(16)
    ) dut (
        .sclk     (clk),
        .reset    (reset),
        .RxD      (RxD),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Model side: each good frame sent queues its byte; every strobe
    // must pop a matching byte and be exactly one cycle wide.
    always @(negedge clk) begin
        if (busy) busy_seen = 1'b1;
        if (rx_valid) begin
            n_valid++;
            chk("valid_1cyc", 32'(prev_v), 0);
            chk("busy_at_valid", 32'(busy), 0);
            if (exp_q.size() == 0) begin
                chk("unexp_valid", 1, 0);
            end else begin
                last_good = exp_q.pop_front();
                chk("rx_data", 32'(rx_data), 32'(last_good));
            end
        end
        if (frame_err) begin
            n_ferr++;
            chk("ferr_1cyc", 32'(prev_f), 0);
            chk("ferr_hold", 32'(rx_data), 32'(last_good));
        end
        prev_v = rx_valid;
        prev_f = frame_err;
    end

    task automatic send(input logic [7:0] b, input bit stop_ok,
                        input real bit_ns);
        if (stop_ok) begin
            exp_q.push_back(b);
            exp_valid++;
        end else begin
            exp_ferr++;
        end
        RxD = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            RxD = b[i];
            #(bit_ns);
        end
        RxD = stop_ok;
        #(bit_ns);
        RxD = 1'b1;
    endtask

    task automatic idle(input real ns);
        RxD = 1'b1;
        #(ns);
    endtask

    initial begin
        logic [7:0] b;
        bit         ok;
        real        bt;
        int         v0;
        int         f0;

        repeat (4) @(negedge clk);
        chk("rst_data", 32'(rx_data), 0);
        chk("rst_valid", 32'(rx_valid), 0);
        chk("rst_ferr", 32'(frame_err), 0);
        chk("rst_busy", 32'(busy), 0);
        reset = 1'b0;
        idle(5 * BIT_NS);

        send(8'h55, 1'b1, BIT_NS);
        idle(2 * BIT_NS);
        send(8'hA3, 1'b1, BIT_NS);
        idle(2 * BIT_NS);
        chk("two_valid", 32'(n_valid), 2);
        chk("no_ferr", 32'(n_ferr), 0);
        chk("data_a3", 32'(rx_data), 32'h A3);

        busy_seen = 1'b0;
        v0 = n_valid;
        f0 = n_ferr;
        RxD = 1'b0;
        #(40 * CLK_NS);
        RxD = 1'b1;
        idle(2 * BIT_NS);
        chk("glitch_busy", 32'(busy_seen), 1);
        chk("glitch_idle", 32'(busy), 0);
        chk("glitch_valid", 32'(n_valid), 32'(v0));
        chk("glitch_ferr", 32'(n_ferr), 32'(f0));
        chk("glitch_data", 32'(rx_data), 32'h A3);

        send(8'h3C, 1'b0, BIT_NS);
        RxD = 1'b0;
        #(2 * BIT_NS);
        idle(2 * BIT_NS);
        chk("ferr_count", 32'(n_ferr), 1);
        chk("ferr_data", 32'(rx_data), 32'h A3);
        send(8'h81, 1'b1, BIT_NS);
        idle(2 * BIT_NS);
        chk("after_ferr", 32'(rx_data), 32'h 81);

        v0 = n_valid;
        RxD = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 4; i++) begin
            RxD = 1'b1;
            #(BIT_NS);
        end
        #(BIT_NS / 2);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        last_good = 8'h00;
        chk("mid_rst_data", 32'(rx_data), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_valid", 32'(rx_valid), 0);
        chk("mid_rst_ferr", 32'(frame_err), 0);
        idle(5 * BIT_NS);
        chk("mid_rst_none", 32'(n_valid), 32'(v0));
        send(8'h12, 1'b1, BIT_NS);
        idle(2 * BIT_NS);
        chk("after_rst", 32'(rx_data), 32'h 12);

        v0 = n_valid;
        send(8'h00, 1'b1, TX_NS);
        send(8'hFF, 1'b1, TX_NS);
        send(8'h7E, 1'b1, TX_NS);
        idle(2 * BIT_NS);
        chk("b2b_count", 32'(n_valid - v0), 3);
        chk("b2b_last", 32'(rx_data), 32'h 7E);

        // Random bytes, +/-2.5% baud skew, occasional bad stop bit.
        for (int k = 0; k < 24; k++) begin
            b  = 8'($urandom);
            ok = ($urandom_range(0, 5) != 0);
            bt = BIT_NS * real'(975 + $urandom_range(0, 50)) / 1000.0;
            send(b, ok, bt);
            if (!ok) begin
                RxD = 1'b0;
                #(2 * bt);
                idle(bt);
            end
            idle(bt * real'($urandom_range(0, 3)) / 2.0);
        end
        idle(3 * BIT_NS);

        chk("tot_valid", 32'(n_valid), 32'(exp_valid));
        chk("tot_ferr", 32'(n_ferr), 32'(exp_ferr));
        chk("q_empty", 32'(exp_q.size()), 0);
        chk("end_busy", 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
